uart_autobaud: RTL

Automatic baud-rate calibration controller for the UART receive path. On request it waits for an idle line, times a 0x55 sync character sent by the host, derives the per-bit clock divider, and drives it into the receiver's `clk_div` input. It sits between register/control logic and `uart_rx`, and owns the divider value: a programmed default at reset, a measured value after a successful calibration.

---
 rtl/uart_autobaud_if.sv | 28 ++
 rtl/uart_autobaud.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_autobaud_if : control/status and serial-line bundle for uart_autobaud
// Revision: 1.0
// ---------------------------------------------------------------------------
interface uart_autobaud_if #(
   parameter int CLK_DIV_WIDTH = 8
);
   logic                     start;
   logic                     rx;
   logic [CLK_DIV_WIDTH-1:0] clk_div_default;
   logic [CLK_DIV_WIDTH-1:0] clk_div;
   logic                     busy;
   logic                     done;
   logic                     error;
   logic                     locked;

   modport master (
      output start, rx, clk_div_default,
      input  clk_div, busy, done, error, locked
   );

   modport slave (
      input  start, rx, clk_div_default,
      output clk_div, busy, done, error, locked
   );
endinterface
`default_nettype wire

// File: rtl/uart_autobaud.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_autobaud : times a 0x55 sync character and derives the UART bit divider
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_autobaud #(
   parameter int   CLK_DIV_WIDTH = 8,
   parameter int   IDLE_CYCLES   = 16,
   parameter logic START_BIT     = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   uart_autobaud_if.slave bus
);
   localparam int W   = CLK_DIV_WIDTH;
   localparam int IW  = W + 1;
   localparam int TW  = W + 3;
   localparam int MW  = W + 4;
   localparam int IDW = $clog2(IDLE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_IDLE  = 2'd1,
      WAIT_START = 2'd2,
      MEASURE    = 2'd3
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           rx_s;
   logic           rx_ss;
   logic [IDW-1:0] idle_cnt;
   logic [IW-1:0]  icnt;
   logic [TW-1:0]  tcnt;
   logic [2:0]     eidx;
   logic [W+1:0]   i1;
   logic [W-1:0]   clk_div;
   logic           busy;
   logic           done;
   logic           error;
   logic           locked;

   logic           fall;
   logic           start_ok;
   logic           go_measure;
   logic           do_done;
   logic           do_fail;
   logic [W+1:0]   intv;
   logic [MW-1:0]  a4;
   logic [MW-1:0]  i1_ext;
   logic [MW-1:0]  b3;
   logic [MW-1:0]  b5;
   logic [MW-1:0]  n_cyc;
   logic [W:0]     div;

   assign fall   = (rx_s == START_BIT) && (rx_ss == ~START_BIT);
   assign intv   = (W+2)'(icnt) + (W+2)'(1);
   assign a4     = MW'(intv) << 2;
   assign i1_ext = MW'(i1);
   assign b3     = (i1_ext << 1) + i1_ext;
   assign b5     = (i1_ext << 2) + i1_ext;
   assign n_cyc  = MW'(tcnt) + MW'(1);
   // Round to nearest: N spans eight bit periods.
   assign div    = (W+1)'((n_cyc + MW'(4)) >> 3);

   always_comb begin
      state_next = state;
      start_ok   = 1'b0;
      go_measure = 1'b0;
      do_done    = 1'b0;
      do_fail    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !done && !error) begin
               state_next = WAIT_IDLE;
               start_ok   = 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (idle_cnt == IDW'(IDLE_CYCLES)) state_next = WAIT_START;
         end
         WAIT_START: begin
            if (fall) begin
               state_next = MEASURE;
               go_measure = 1'b1;
            end
         end
         MEASURE: begin
            // An edge in the timeout cycle still counts as a valid edge.
            if (fall) begin
               if (eidx >= 3'd2 && (a4 < b3 || a4 > b5)) begin
                  do_fail = 1'b1;
               end else if (eidx == 3'd4) begin
                  if (div[W] || div[W-1:1] == '0) do_fail = 1'b1;
                  else                            do_done = 1'b1;
               end
            end else if (&icnt) begin
               do_fail = 1'b1;
            end
            if (do_fail || do_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rx_s     <= ~START_BIT;
         rx_ss    <= ~START_BIT;
         idle_cnt <= '0;
         icnt     <= '0;
         tcnt     <= '0;
         eidx     <= '0;
         i1       <= '0;
         clk_div  <= bus.clk_div_default;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         locked   <= 1'b0;
      end else begin
         state <= state_next;
         rx_s  <= bus.rx;
         rx_ss <= rx_s;
         done  <= do_done;
         error <= do_fail;

         if (start_ok) begin
            busy   <= 1'b1;
            locked <= 1'b0;
         end
         if (do_done || do_fail) busy <= 1'b0;
         if (do_done) begin
            clk_div <= div[W-1:0];
            locked  <= 1'b1;
         end

         if (state == WAIT_IDLE) begin
            if (rx_s == START_BIT)                   idle_cnt <= '0;
            else if (idle_cnt != IDW'(IDLE_CYCLES)) idle_cnt <= idle_cnt + IDW'(1);
         end else begin
            idle_cnt <= '0;
         end

         if (go_measure) begin
            icnt <= '0;
            tcnt <= '0;
            eidx <= 3'd1;
         end else if (state == MEASURE) begin
            tcnt <= tcnt + TW'(1);
            if (fall) begin
               icnt <= '0;
               eidx <= eidx + 3'd1;
               if (eidx == 3'd1) i1 <= intv;
            end else begin
               icnt <= icnt + IW'(1);
            end
         end
      end
   end

   assign bus.clk_div = clk_div;
   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.error   = error;
   assign bus.locked  = locked;
endmodule
`default_nettype wire
